// File: rtl/store_merge_unit.sv
// Store path for sw/sh/sb into word-organised memory; sub-word stores use read-modify-write.
// Optional macro STORE_ALIGN_CHECK_EN rejects misaligned sw/sh through the ERR state.
module store_merge_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] reg_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        store_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;
    localparam logic [1:0] ST_IL = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  type_q;
    logic [1:0]  offs_q;
    logic [31:0] data_q;
    logic [31:0] addr_q;
    logic [31:0] merge_q;
    logic        take_s;
    logic        misaligned_s;

    // Little-endian lane insert; sw passes the operand through unchanged.
    function automatic logic [31:0] merge_word(input logic [31:0] word,
                                               input logic [1:0]  st,
                                               input logic [1:0]  offs,
                                               input logic [31:0] data);
        logic [31:0] res;
        res = word;
        case (st)
            ST_SH: begin
                if (offs[1]) res[31:16] = data[15:0];
                else         res[15:0]  = data[15:0];
            end
            ST_SB: begin
                case (offs)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    2'd3:    res[31:24] = data[7:0];
                    default: res        = word;
                endcase
            end
            default: res = data;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] st, input logic [1:0] offs);
`ifdef STORE_ALIGN_CHECK_EN
        return ((st == ST_SH) && offs[0]) || ((st == ST_SW) && (offs != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    assign take_s       = (state_q == S_IDLE) && start;
    assign misaligned_s = is_misaligned(store_type, addr[1:0]);

    // Next-state selection for the store sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((store_type == ST_IL) || misaligned_s) state_d = S_ERR;
                    else if (store_type == ST_SW)              state_d = S_WRITE;
                    else                                       state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Request capture at start and read-data capture at the end of WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            type_q  <= 2'b00;
            offs_q  <= 2'b00;
            data_q  <= 32'h0000_0000;
            addr_q  <= 32'h0000_0000;
            merge_q <= 32'h0000_0000;
        end else begin
            if (take_s) begin
                type_q <= store_type;
                offs_q <= addr[1:0];
                data_q <= reg_data;
                addr_q <= {addr[31:2], 2'b00};
            end else begin
                type_q <= type_q;
                offs_q <= offs_q;
                data_q <= data_q;
                addr_q <= addr_q;
            end
            if (state_q == S_WAIT) merge_q <= mem_rdata;
            else                   merge_q <= merge_q;
        end
    end

    // Outputs derive only from registered state and latched operands.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = merge_word(merge_q, type_q, offs_q, data_q);
        mem_wr    = (state_q == S_WRITE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE) || (state_q == S_ERR);
        store_err = (state_q == S_ERR);
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: sw, sh, sb, illegal, misaligned, busy-start and mid-RMW reset.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] reg_data;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        store_err;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int wr_before;
    logic [31:0] mword_addr = 32'h0000_0000;
    logic [31:0] mword      = 32'h0000_0000;

    store_merge_unit dut (
        .clk(clk), .reset(reset), .start(start), .store_type(store_type),
        .addr(addr), .reg_data(reg_data), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .store_err(store_err)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, returns junk unless the modelled word is addressed during a read.
    always @(posedge clk) begin
        if (busy === 1'b1 && mem_wr === 1'b0 && mem_addr === mword_addr) mem_rdata <= mword;
        else                                                              mem_rdata <= 32'hBADB_AD00;
        if (mem_wr === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for cycle 0, then scrambles the inputs to prove they were latched.
    task automatic begin_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        store_type = t;
        addr       = a;
        reg_data   = d;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        store_type = 2'b11;
        addr       = 32'hFFFF_FFFF;
        reg_data   = 32'h0000_0000;
    endtask

    task automatic run_sw(input string tag, input logic [31:0] a, input logic [31:0] d);
        wr_before = wr_count;
        begin_store(2'b00, a, d);
        chk({tag, "_c1_wr"}, {31'd0, mem_wr}, 32'd1);
        chk({tag, "_c1_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_c1_wdata"}, mem_wdata, d);
        chk({tag, "_c1_done"}, {31'd0, done}, 32'd0);
        tick();
        chk({tag, "_c2_done"}, {29'd0, done, store_err, mem_wr}, {29'd0, 3'b100});
        tick();
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_wrcnt"}, wr_count, wr_before + 1);
    endtask

    task automatic run_rmw(input string tag, input logic [1:0] t, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] word, input logic [31:0] exp);
        mword_addr = {a[31:2], 2'b00};
        mword      = word;
        wr_before  = wr_count;
        begin_store(t, a, d);
        chk({tag, "_c1_read"}, {30'd0, busy, mem_wr}, 32'd2);
        chk({tag, "_c1_addr"}, mem_addr, {a[31:2], 2'b00});
        tick();
        chk({tag, "_c2_wait"}, {29'd0, busy, mem_wr, done}, 32'd4);
        tick();
        chk({tag, "_c3_wr"}, {31'd0, mem_wr}, 32'd1);
        chk({tag, "_c3_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_c3_wdata"}, mem_wdata, exp);
        tick();
        chk({tag, "_c4_done"}, {29'd0, done, store_err, mem_wr}, {29'd0, 3'b100});
        tick();
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_wrcnt"}, wr_count, wr_before + 1);
    endtask

    task automatic run_err(input string tag, input logic [1:0] t, input logic [31:0] a);
        wr_before = wr_count;
        begin_store(t, a, 32'h5A5A_5A5A);
        chk({tag, "_c1"}, {28'd0, busy, done, store_err, mem_wr}, {28'd0, 4'b1110});
        tick();
        chk({tag, "_c2"}, {29'd0, busy, done, store_err}, 32'd0);
        chk({tag, "_wrcnt"}, wr_count, wr_before);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        store_type = 2'b00;
        addr       = 32'h0000_0000;
        reg_data   = 32'h0000_0000;
        #3;
        chk("rst_ctrl", {28'd0, busy, done, store_err, mem_wr}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0000_0000);
        chk("rst_wdata", mem_wdata, 32'h0000_0000);
        #9 reset = 1'b1;
        tick();

        run_sw("sw", 32'h0000_0104, 32'hDEAD_BEEF);
        run_rmw("sb", 2'b10, 32'h0000_0202, 32'hFFFF_FFAB, 32'h1122_3344, 32'h11AB_3344);
        run_rmw("sb0", 2'b10, 32'h0000_0210, 32'h0000_00C3, 32'h1122_3344, 32'h1122_33C3);
        run_rmw("sh_hi", 2'b01, 32'h0000_0302, 32'h0000_1234, 32'hAAAA_5555, 32'h1234_5555);
        run_rmw("sh_lo", 2'b01, 32'h0000_0300, 32'h0000_1234, 32'hAAAA_5555, 32'hAAAA_1234);
        run_err("illegal", 2'b11, 32'h0000_0400);
`ifdef STORE_ALIGN_CHECK_EN
        run_err("sh_misal", 2'b01, 32'h0000_0301);
        run_err("sw_misal", 2'b00, 32'h0000_0106);
`else
        run_rmw("sh_misal", 2'b01, 32'h0000_0301, 32'h0000_1234, 32'hAAAA_5555, 32'hAAAA_1234);
        run_sw("sw_misal", 32'h0000_0106, 32'hCAFE_F00D);
`endif

        // Start held high through an sb in progress must not queue a second store.
        mword_addr = 32'h0000_0500;
        mword      = 32'h0102_0304;
        wr_before  = wr_count;
        begin_store(2'b10, 32'h0000_0501, 32'h0000_00EE);
        start      = 1'b1;
        store_type = 2'b00;
        addr       = 32'h0000_0600;
        tick();
        tick();
        chk("busy_c3_wdata", mem_wdata, 32'h0102_EE04);
        tick();
        start = 1'b0;
        chk("busy_c4_done", {31'd0, done}, 32'd1);
        tick();
        chk("busy_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("busy_no_requeue", {31'd0, busy}, 32'd0);
        chk("busy_wrcnt", wr_count, wr_before + 1);

        // Reset during WAIT of an sb abandons the RMW without writing.
        mword_addr = 32'h0000_0200;
        mword      = 32'h1122_3344;
        wr_before  = wr_count;
        begin_store(2'b10, 32'h0000_0202, 32'h0000_0077);
        tick();
        #1 reset = 1'b0;
        #1;
        chk("midrst_ctrl", {28'd0, busy, done, store_err, mem_wr}, 32'd0);
        chk("midrst_wdata", mem_wdata, 32'h0000_0000);
        tick();
        tick();
        chk("midrst_wrcnt", wr_count, wr_before);
        reset = 1'b1;
        tick();
        run_sw("sw_after_rst", 32'h0000_0108, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Write-side counterpart of the write-back data select: takes a register operand from the datapath and stores it to word-organised memory for sw, sh and sb. Sub-word stores use read-modify-write: fetch the containing word, merge the byte or halfword, write the word back. Sits between register B / ALUOut and the memory port, and is sequenced by the control unit through a start/done handshake.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- store_type  in  2  00 sw, 01 sh, 10 sb, 11 illegal.
- addr  in  32  byte address (from ALUOut).
- reg_data  in  32  store operand (from register B).
- mem_rdata  in  32  memory read data; valid the cycle after the address is presented.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_wr  out  1  memory write strobe, one cycle per store.
- mem_wdata  out  32  word to write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- store_err  out  1  one-cycle pulse together with done on a rejected store.

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- IDLE, start=1: latch store_type, addr and reg_data into internal registers. Later input changes are ignored.
  - sw goes to WRITE.
  - sh and sb go to READ.
  - 11 goes to ERR.
  - A misaligned access goes to ERR (see Configuration).
- READ: drive mem_addr; mem_wr=0. Next state is WAIT.
- WAIT: capture mem_rdata into the merge register. Next state is WRITE.
- WRITE: mem_wr=1.
  - sw: mem_wdata = latched reg_data.
  - sh: replace bits [16h+15:16h] of the merged word with reg_data[15:0], where h = addr[1].
  - sb: replace bits [8k+7:8k] with reg_data[7:0], where k = addr[1:0].
  - All other bits keep the read value (little-endian). Next state is DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERR: done=1 and store_err=1 for one cycle; no memory write. Then IDLE.
- start while busy=1 is ignored and is not queued.
- Reset values: state IDLE; mem_addr, mem_wdata and the merge register all 0; mem_wr, busy, done and store_err all 0.
- Reset mid-operation: return to IDLE immediately (asynchronously) and deassert mem_wr. A partially completed RMW never writes.

## Timing
- Cycle numbering: cycle 0 is the edge that samples start.
- sw: WRITE in cycle 1 (mem_wr high), done in cycle 2. Start-to-done latency is 2 cycles.
- sh/sb: READ in cycle 1, WAIT in cycle 2 (mem_rdata captured at the end of this cycle), WRITE in cycle 3, done in cycle 4. Latency is 4 cycles.
- ERR: done and store_err in cycle 1.
- mem_addr is held stable from READ through WRITE.
- Earliest next start is the cycle after done (state is IDLE again). Back-to-back stores issue every 3 or 5 cycles.
- All outputs are registered or decoded from the registered state only. No input-to-output combinational path.

## Configuration
- STORE_ALIGN_CHECK_EN defined:
  - sh with addr[0]=1 goes to ERR.
  - sw with addr[1:0]≠0 goes to ERR.
  - Memory is untouched in both cases.
- Not defined:
  - Misalignment is never flagged.
  - sw ignores addr[1:0].
  - sh ignores addr[0] and uses addr[1].
  - store_err is raised only for store_type 11.

## Test plan
- sw: addr=0x0000_0104, reg_data=0xDEADBEEF -> mem_wr in cycle 1, mem_addr=0x104, mem_wdata=0xDEADBEEF; done in cycle 2; no read phase.
- sb: addr=0x0000_0202, mem word=0x11223344, reg_data=0xFFFF_FFAB -> mem_wdata=0x11AB3344 in cycle 3; done in cycle 4.
- sh: addr=0x0000_0302, mem word=0xAAAA_5555, reg_data=0x0000_1234 -> mem_wdata=0x1234_5555. With addr=0x300 -> mem_wdata=0xAAAA_1234.
- Misaligned sh at addr=0x301:
  - STORE_ALIGN_CHECK_EN defined -> done and store_err pulse in cycle 1; mem_wr never asserted.
  - Not defined -> store proceeds with h=0.
- Illegal and busy cases:
  - store_type=11 -> store_err in cycle 1, no write.
  - start pulsed during an sb in progress -> ignored; only one mem_wr pulse occurs.
- Reset asserted during WAIT of an sb -> state IDLE, mem_wr stays 0, busy=0. A fresh sw after release completes normally in 2 cycles.
